noise_gate: RTL and testbench

Per-channel noise gate with hysteresis, hold and gain ramps. It sits between the sample-select/SRAM playback logic and the reverb stage; one instance is placed per channel. Each instance consumes one 16-bit signed sample per strobe and tracks its peak envelope. It outputs the sample scaled by a 9-bit gain that ramps between 0 (closed) and 256 (unity), which suppresses the codec hiss floor before reverberation.

---
 rtl/noise_gate_if.sv | 19 +
 rtl/noise_gate.sv | 141 ++++++++++++++
 tb/tb_noise_gate.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/noise_gate_if.sv
// Sample stream bundle for noise_gate: strobed input sample in, gated sample plus gain status out.
interface noise_gate_if;
  logic               in_stb;
  logic signed [15:0] din;
  logic               out_stb;
  logic signed [15:0] dout;
  logic               gate_open;
  logic        [8:0]  gain;

  modport master (
    output in_stb, din,
    input  out_stb, dout, gate_open, gain
  );

  modport slave (
    input  in_stb, din,
    output out_stb, dout, gate_open, gain
  );
endinterface

// File: rtl/noise_gate.sv
// Per-channel noise gate: peak envelope, hysteresis/hold state machine, gain ramp, 3-stage pipeline.
// NOISE_GATE_RAMP_EN enables gradual attack/release ramps; otherwise the gain steps 0 <-> 256 at once.
module noise_gate #(
  parameter logic [15:0] OPEN_TH      = 16'd1024,
  parameter logic [15:0] CLOSE_TH     = 16'd512,
  parameter int unsigned DECAY_SHIFT  = 6,
  parameter logic [15:0] HOLD_SAMPLES = 16'd2400,
  parameter logic [8:0]  ATTACK_STEP  = 9'd16,
  parameter logic [8:0]  RELEASE_STEP = 9'd1
) (
  input logic         clk,
  input logic         reset,
  noise_gate_if.slave bus
);

  localparam logic [8:0] GAIN_MAX = 9'd256;

`ifdef NOISE_GATE_RAMP_EN
  localparam bit         RAMP    = 1'b1;
  localparam logic [8:0] UP_STEP = ATTACK_STEP;
  localparam logic [8:0] DN_STEP = RELEASE_STEP;
`else
  // Steps of at least full scale saturate the gain in a single sample.
  localparam bit         RAMP    = 1'b0;
  localparam logic [8:0] UP_STEP = (ATTACK_STEP > GAIN_MAX) ? ATTACK_STEP : GAIN_MAX;
  localparam logic [8:0] DN_STEP = (RELEASE_STEP > GAIN_MAX) ? RELEASE_STEP : GAIN_MAX;
`endif

  typedef enum logic [2:0] {StClosed, StAttack, StOpen, StHold, StRelease} state_e;

  state_e             state_q;
  logic               v1_q, v2_q, out_stb_q, gate_open_q;
  logic        [15:0] env_q, hold_cnt_q;
  logic signed [15:0] din1_q, din2_q, dout_q;
  logic        [8:0]  gain_q;

  logic [15:0] mag, decayed, env_d;
  logic [9:0]  gain_sum;
  logic [8:0]  gain_up, gain_dn;
  logic signed [25:0] prod;
  logic unused_prod;

  always_comb begin
    if (bus.din == 16'sh8000) begin
      mag = 16'h7fff;
    end else if (bus.din[15]) begin
      mag = ~bus.din + 16'd1;
    end else begin
      mag = bus.din;
    end
    decayed = env_q - (env_q >> DECAY_SHIFT);
    env_d   = (mag >= decayed) ? mag : decayed;
  end

  assign gain_sum = {1'b0, gain_q} + {1'b0, UP_STEP};
  assign gain_up  = (gain_sum > {1'b0, GAIN_MAX}) ? GAIN_MAX : gain_sum[8:0];
  assign gain_dn  = (gain_q > DN_STEP) ? (gain_q - DN_STEP) : 9'd0;

  assign prod        = $signed({{10{din2_q[15]}}, din2_q}) * $signed({17'd0, gain_q});
  assign unused_prod = ^{prod[25:24], prod[7:0]};

  // Stage 1 (envelope) and stage 3 (gain multiply) datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      out_stb_q <= 1'b0;
      env_q     <= 16'd0;
      din1_q    <= 16'sd0;
      din2_q    <= 16'sd0;
      dout_q    <= 16'sd0;
    end else begin
      v1_q      <= bus.in_stb;
      v2_q      <= v1_q;
      out_stb_q <= v2_q;
      if (bus.in_stb) begin
        env_q  <= env_d;
        din1_q <= bus.din;
      end
      if (v1_q) din2_q <= din1_q;
      if (v2_q) dout_q <= prod[23:8];
    end
  end

  // Stage 2: gate state machine, stepped once per sample using the freshly updated envelope.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StClosed;
      gain_q      <= 9'd0;
      hold_cnt_q  <= 16'd0;
      gate_open_q <= 1'b0;
    end else if (v1_q) begin
      unique case (state_q)
        StClosed: begin
          if (env_q >= OPEN_TH) begin
            gain_q      <= gain_up;
            gate_open_q <= 1'b1;
            state_q     <= (gain_up == GAIN_MAX) ? StOpen : StAttack;
          end
        end
        StAttack: begin
          gain_q <= gain_up;
          if (gain_up == GAIN_MAX) state_q <= StOpen;
        end
        StOpen: begin
          if (env_q < CLOSE_TH) begin
            hold_cnt_q <= HOLD_SAMPLES;
            state_q    <= StHold;
          end
        end
        StHold: begin
          if (env_q >= OPEN_TH) begin
            state_q <= StOpen;
          end else begin
            hold_cnt_q <= hold_cnt_q - 16'd1;
            if (hold_cnt_q == 16'd1) state_q <= StRelease;
          end
        end
        StRelease: begin
          if (env_q >= OPEN_TH) begin
            gain_q  <= gain_up;
            state_q <= RAMP ? StAttack : StOpen;
          end else begin
            gain_q <= gain_dn;
            if (gain_dn == 9'd0) begin
              gate_open_q <= 1'b0;
              state_q     <= StClosed;
            end
          end
        end
        default: state_q <= StClosed;
      endcase
    end
  end

  assign bus.out_stb   = out_stb_q;
  assign bus.dout      = dout_q;
  assign bus.gate_open = gate_open_q;
  assign bus.gain      = gain_q;

endmodule

// File: tb/tb_noise_gate.sv
// Self-checking bench for noise_gate: directed scenarios plus random bursts against a sample-level model.
module tb_noise_gate;

  localparam int DS       = 1;
  localparam int HOLD     = 4;
  localparam int OPEN_TH  = 1024;
  localparam int CLOSE_TH = 512;
`ifdef NOISE_GATE_RAMP_EN
  localparam int A_STEP = 64;
  localparam int R_STEP = 64;
  localparam bit RAMP   = 1'b1;
`else
  localparam int A_STEP = 256;
  localparam int R_STEP = 256;
  localparam bit RAMP   = 1'b0;
`endif

  localparam int M_CLOSED = 0, M_ATTACK = 1, M_OPEN = 2, M_HOLD = 3, M_RELEASE = 4;

  typedef struct { int due; int val; } dexp_t;
  typedef struct { int due; int gain; bit open; } gexp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  noise_gate_if bus ();

  noise_gate #(
    .DECAY_SHIFT (1),
    .HOLD_SAMPLES(16'd4),
    .ATTACK_STEP (9'd64),
    .RELEASE_STEP(9'd64)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  dexp_t dq[$];
  gexp_t gq[$];
  int    obs[$];

  // Behavioural model state: one update per accepted sample.
  int m_env, m_gain, m_hold, m_st;

  task automatic chk(input string tag, input integer got, input integer want);
    n_cmp++;
    assert (got === want)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int sat_up(input int g);
    return (g + A_STEP > 256) ? 256 : g + A_STEP;
  endfunction

  function automatic int sat_dn(input int g);
    return (g - R_STEP < 0) ? 0 : g - R_STEP;
  endfunction

  task automatic model_reset();
    m_env = 0; m_gain = 0; m_hold = 0; m_st = M_CLOSED;
  endtask

  task automatic model_sample(input int x, output int y);
    int a, d, p;
    a = (x < 0) ? -x : x;
    if (a > 32767) a = 32767;
    d = m_env - (m_env >> DS);
    m_env = (a >= d) ? a : d;
    case (m_st)
      M_CLOSED: if (m_env >= OPEN_TH) begin
        m_gain = sat_up(m_gain);
        m_st   = (m_gain == 256) ? M_OPEN : M_ATTACK;
      end
      M_ATTACK: begin
        m_gain = sat_up(m_gain);
        if (m_gain == 256) m_st = M_OPEN;
      end
      M_OPEN: if (m_env < CLOSE_TH) begin
        m_st = M_HOLD; m_hold = HOLD;
      end
      M_HOLD: if (m_env >= OPEN_TH) m_st = M_OPEN;
      else begin
        m_hold = m_hold - 1;
        if (m_hold == 0) m_st = M_RELEASE;
      end
      default: if (m_env >= OPEN_TH) begin
        m_gain = sat_up(m_gain);
        m_st   = RAMP ? M_ATTACK : M_OPEN;
      end else begin
        m_gain = sat_dn(m_gain);
        if (m_gain == 0) m_st = M_CLOSED;
      end
    endcase
    p = x * m_gain;
    y = (p >= 0) ? p / 256 : -((-p + 255) / 256);
  endtask

  task automatic send(input int x, input int gap);
    int y;
    dexp_t de;
    gexp_t ge;
    @(negedge clk);
    bus.in_stb = 1'b1;
    bus.din    = 16'(x);
    model_sample(x, y);
    de.due = cyc + 3; de.val = y;
    ge.due = cyc + 2; ge.gain = m_gain; ge.open = (m_st != M_CLOSED);
    dq.push_back(de);
    gq.push_back(ge);
    repeat (gap) begin
      @(negedge clk);
      bus.in_stb = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    bus.in_stb = 1'b0;
    while ((dq.size() != 0 || gq.size() != 0) && n < 16) begin
      @(negedge clk);
      #1;
      n++;
    end
    #1;
    chk("drain_outstanding", dq.size(), 0);
  endtask

  task automatic chk_obs(input string tag, input int idx, input int want);
    if (idx < obs.size()) chk(tag, obs[idx], want);
    else chk({tag, "_count"}, obs.size(), idx + 1);
  endtask

  // In-flight strobes are held high into reset to confirm they are discarded.
  task automatic do_reset();
    @(negedge clk);
    #1;
    reset      = 1'b0;
    bus.in_stb = 1'b1;
    bus.din    = 16'sd5000;
    dq.delete();
    gq.delete();
    model_reset();
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_stb", bus.out_stb, 0);
      chk("rst_dout", bus.dout, 0);
      chk("rst_gain", bus.gain, 0);
      chk("rst_gate_open", bus.gate_open, 0);
    end
    bus.in_stb = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic int rand_loud();
    int m;
    if ($urandom_range(0, 7) == 0) return -32768;
    m = int'($urandom_range(0, 32767));
    return ($urandom_range(0, 1) != 0) ? -m : m;
  endfunction

  function automatic int rand_quiet();
    int m;
    m = int'($urandom_range(0, 900));
    return ($urandom_range(0, 1) != 0) ? -m : m;
  endfunction

  always @(negedge clk) begin
    dexp_t e;
    gexp_t g;
    if (bus.out_stb === 1'b1) begin
      if (dq.size() == 0) begin
        chk("spurious_out_stb", bus.out_stb, 0);
      end else begin
        e = dq.pop_front();
        chk("out_stb_cycle", cyc, e.due);
        chk("dout", bus.dout, e.val);
        obs.push_back(int'(bus.dout));
      end
    end else if (dq.size() != 0 && dq[0].due <= cyc) begin
      e = dq.pop_front();
      chk("missing_out_stb", bus.out_stb, 1);
    end
    if (gq.size() != 0 && gq[0].due <= cyc) begin
      g = gq.pop_front();
      chk("gain", bus.gain, g.gain);
      chk("gate_open", bus.gate_open, g.open);
    end
  end

  initial begin
    int att_exp[5];
    int hr_exp[11];
    int rt_gain, rt_dout, fs_dout;
`ifdef NOISE_GATE_RAMP_EN
    att_exp = '{1000, 2000, 3000, 4000, 4000};
    hr_exp  = '{10, 10, 10, 10, 10, 10, 10, 7, 5, 2, 0};
    rt_gain = 192; rt_dout = 3000; fs_dout = -24576;
`else
    att_exp = '{4000, 4000, 4000, 4000, 4000};
    hr_exp  = '{10, 10, 10, 10, 10, 10, 10, 0, 0, 0, 0};
    rt_gain = 256; rt_dout = 4000; fs_dout = -32768;
`endif
    bus.in_stb = 1'b0;
    bus.din    = 16'sd0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("init_dout", bus.dout, 0);
    chk("init_gain", bus.gain, 0);
    chk("init_gate_open", bus.gate_open, 0);
    chk("init_out_stb", bus.out_stb, 0);
    #1;
    reset = 1'b1;

    obs.delete();
    for (int i = 0; i < 10; i++) send(100, i % 2);
    drain();
    for (int i = 0; i < 10; i++) chk_obs("below_dout", i, 0);
    chk("below_gate_open", bus.gate_open, 0);

    obs.delete();
    for (int i = 0; i < 5; i++) send(4000, 1);
    drain();
    for (int i = 0; i < 5; i++) chk_obs("attack_dout", i, att_exp[i]);
    chk("attack_gain", bus.gain, 256);
    chk("attack_gate_open", bus.gate_open, 1);

    obs.delete();
    for (int i = 0; i < 11; i++) send(10, 0);
    drain();
    for (int i = 0; i < 11; i++) chk_obs("hold_rel_dout", i, hr_exp[i]);
    chk("hold_rel_gain", bus.gain, 0);
    chk("hold_rel_gate_open", bus.gate_open, 0);

    for (int i = 0; i < 4; i++) send(4000, 0);
    for (int i = 0; i < 9; i++) send(10, 0);
    drain();
    obs.delete();
    send(4000, 0);
    drain();
    chk("retrig_gain", bus.gain, rt_gain);
    chk_obs("retrig_dout", 0, rt_dout);
    send(4000, 0);
    drain();
    chk("retrig2_gain", bus.gain, 256);
    chk_obs("retrig2_dout", 1, 4000);

    obs.delete();
    send(-32768, 0);
    drain();
    chk_obs("fullscale_unity", 0, -32768);
    for (int i = 0; i < 13; i++) send(0, 0);
    send(-32768, 0);
    drain();
    chk_obs("fullscale_partial", 14, fs_dout);

    for (int i = 0; i < 3; i++) send(4000, 0);
    do_reset();

    for (int s = 0; s < 24; s++) begin
      int nl, nq;
      nl = int'($urandom_range(1, 6));
      nq = int'($urandom_range(0, 24));
      for (int k = 0; k < nl; k++) send(rand_loud(), int'($urandom_range(0, 2)));
      for (int k = 0; k < nq; k++) send(rand_quiet(), int'($urandom_range(0, 2)));
      if (s == 12) do_reset();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
